data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the pipelined CPU's data port (Daddr/Dout/DMC/Dread).
//  Serves word loads and byte/half/word stores to a local word RAM.
//  Serves an MMIO window at 0xF000_0000 with:
//   - an 8-word parameter FIFO draining to the mixer core over a valid/ready link;
//   - a status register;
//   - a free-running cycle counter.
// PARAMETERS
//  RAM_AWIDTH   10  RAM word-address bits (2^RAM_AWIDTH 32-bit words)
//  FIFO_LOG2    3   log2 of parameter FIFO depth (depth = 8)
// PORTS
//  clk          in   1   rising-edge clock, sole clock domain
//  reset        in   1   synchronous, active-high
//  Daddr        in   32  CPU data byte address (MEM stage)
//  Dout         in   32  CPU store data, already lane-aligned
//  DMC          in   2   store control: 00 none, 01 byte, 10 half, 11 word
//  Dread        in   1   CPU load request
//  Din          out  32  load data to CPU, full aligned word
//  param_data   out  32  FIFO head word to mixer core
//  param_valid  out  1   param_data valid
//  param_ready  in   1   mixer core accepts head word
// BEHAVIOUR
//  Reset state:
//   - FIFO empty; param_valid=0; param_data=0.
//   - cycle counter=0; overflow and misalign flags=0.
//   - RAM contents are not reset. While reset=1, Din=0 and all stores are ignored.
//  Decode: MMIO when Daddr[31:28]==4'hF, else RAM.
//   - RAM word index = Daddr[RAM_AWIDTH+1:2]; upper bits are ignored, so addresses alias/wrap.
//  Loads:
//   - Din is combinational, same cycle as Daddr/Dread: the CPU samples it in MEM, no wait states.
//   - Din=0 when Dread=0.
//   - RAM returns the full word; the CPU does byte/half extraction.
//  Stores commit on the rising clk edge when DMC!=00. Lanes are big-endian: byte 0 = bits[31:24].
//   - byte: lane Daddr[1:0].
//   - half: Daddr[1]=0 -> [31:16], Daddr[1]=1 -> [15:0].
//   - word: all four lanes.
//   - Misaligned store (half with Daddr[0]=1, or word with Daddr[1:0]!=0): dropped, misalign flag set (sticky).
//   - A load and a store to the same word in one cycle: Din shows the pre-store contents.
//  MMIO map (word offsets Daddr[3:2]; other offsets read 0 and ignore writes):
//   - 0x0 FIFO_PUSH: any DMC!=00 pushes Dout as a whole word. Reads return 0.
//   - 0x4 STATUS: read {24'b0, count[3:0], 1'b0, ovf, mis, full}.
//     Any store to STATUS clears ovf and mis.
//     A set and a clear in the same cycle: set wins.
//   - 0x8 CYCLES: 32-bit counter, +1 every non-reset cycle, wraps 0xFFFF_FFFF -> 0.
//     A store loads it with 0; counting resumes the next cycle.
//  FIFO:
//   - Circular buffer with FIFO_LOG2-bit read/write pointers (natural wrap) and a (FIFO_LOG2+1)-bit count.
//   - Pop when param_valid && param_ready. param_valid = (count!=0).
//   - param_data = head entry, registered; valid the cycle after a push into an empty FIFO.
//     No fall-through: push-to-valid latency is 1 cycle.
//   - Push when full without a same-cycle pop: word dropped, ovf set, contents and count unchanged.
//   - Push when full with a same-cycle pop: both happen, count stays 8.
//   - Push when empty with param_ready=1: word is not popped that cycle (head not yet valid).
//   - Reset mid-stream: FIFO flushed; any word not yet popped is lost.
// TESTING
//  1) Word store 0x1234_5678 @0x40, then load @0x40 -> Din=0x1234_5678 in the load's cycle.
//  2) Byte 0xAB store @0x41 (Dout=0x00AB_0000, DMC=01) over 0xFFFF_FFFF -> reload gives 0xFFAB_FFFF.
//     Then half store @0x42 (Dout=0x0000_BEEF) -> reload gives 0xFFAB_BEEF.
//  3) Word store @0x43 -> RAM unchanged; STATUS read gives mis=1.
//     Store to 0xF000_0004 -> STATUS=0.
//  4) Push 9 words (1..9) with param_ready=0 -> STATUS count=8, full=1, ovf=1.
//     Then hold param_ready=1 -> data 1..8 in order, param_valid drops after 8 beats.
//  5) FIFO full, push 0xCAFE with a same-cycle pop -> count stays 8, ovf stays 0, 0xCAFE emerges last.
//  6) Store to 0xF000_0008, idle 5 cycles, read -> 5.
//     Assert reset mid-FIFO -> param_valid=0 next cycle, count=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU data-port and mixer parameter-link signals shared by the data memory responder.
// The slave modport is the responder's view; master is the CPU/mixer view.
interface data_mem_responder_if;
  logic [31:0] Daddr;
  logic [31:0] Dout;
  logic [1:0]  DMC;
  logic        Dread;
  logic [31:0] Din;
  logic [31:0] param_data;
  logic        param_valid;
  logic        param_ready;

  modport master (
    output Daddr, Dout, DMC, Dread, param_ready,
    input  Din, param_data, param_valid
  );

  modport slave (
    input  Daddr, Dout, DMC, Dread, param_ready,
    output Din, param_data, param_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-port responder: local word RAM with big-endian byte/half/word stores, plus an
// MMIO window holding a parameter FIFO to the mixer, a status register and a cycle counter.
module data_mem_responder #(
  parameter int RAM_AWIDTH = 10,
  parameter int FIFO_LOG2  = 3
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = FIFO_LOG2 + 1;

  // Big-endian lane enables: lane 0 is bits [31:24].
  function automatic logic [3:0] lane_mask(input logic [1:0] dmc, input logic [1:0] a);
    logic [3:0] m;
    case (dmc)
      2'b01:   m = 4'b1000 >> a;
      2'b10:   m = a[1] ? 4'b0011 : 4'b1100;
      2'b11:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = m[3-i] ? new_w[31-8*i -: 8] : old_w[31-8*i -: 8];
    return r;
  endfunction

  logic [31:0]           ram [2**RAM_AWIDTH];
  logic [RAM_AWIDTH-1:0] ram_idx;
  logic                  is_mmio;
  logic [1:0]            mmio_off;
  logic                  is_store;
  logic                  misalign;
  logic                  ram_we;
  logic                  mis_set;
  logic                  status_clr;
  logic                  cyc_clr;

  logic [FIFO_LOG2-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]         count, cnt_nxt;
  logic [31:0]           fifo_mem [DEPTH];
  logic [31:0]           head_q, head_nxt;
  logic                  full, push_req, push_ok, pop, ovf_set;
  logic                  ovf, mis;
  logic [31:0]           cycles;
  logic [31:0]           status;
  logic [31:0]           rd_data;
  logic                  unused_addr;

  assign unused_addr = ^bus.Daddr[27:RAM_AWIDTH+2];

  assign ram_idx  = bus.Daddr[RAM_AWIDTH+1:2];
  assign is_mmio  = (bus.Daddr[31:28] == 4'hF);
  assign mmio_off = bus.Daddr[3:2];
  assign is_store = !reset && (bus.DMC != 2'b00);
  assign misalign = ((bus.DMC == 2'b10) && bus.Daddr[0]) ||
                    ((bus.DMC == 2'b11) && (bus.Daddr[1:0] != 2'b00));

  assign ram_we     = is_store && !is_mmio && !misalign;
  assign mis_set    = is_store && !is_mmio && misalign;
  assign status_clr = is_store && is_mmio && (mmio_off == 2'd1);
  assign cyc_clr    = is_store && is_mmio && (mmio_off == 2'd2);

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= lane_merge(ram[ram_idx], bus.Dout, lane_mask(bus.DMC, bus.Daddr[1:0]));
  end

  // FIFO handshake; a push into an empty FIFO is never popped the same cycle since valid is 0.
  assign full        = (count == CW'(DEPTH));
  assign bus.param_valid = (count != '0);
  assign pop         = bus.param_valid && bus.param_ready;
  assign push_req    = is_store && is_mmio && (mmio_off == 2'd0);
  assign push_ok     = push_req && (!full || pop);
  assign ovf_set     = push_req && full && !pop;
  assign rd_nxt      = rd_ptr + FIFO_LOG2'(pop);
  assign cnt_nxt     = count + CW'(push_ok) - CW'(pop);

  always_comb begin
    head_nxt = '0;
    if (cnt_nxt != '0) begin
      if (push_ok && (wr_ptr == rd_nxt))
        head_nxt = bus.Dout;
      else
        head_nxt = fifo_mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= bus.Dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_LOG2'(push_ok);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      head_q <= head_nxt;
    end
  end

  assign bus.param_data = head_q;

  // Sticky flags: a set in the same cycle as a STATUS store wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      mis <= 1'b0;
    end else begin
      ovf <= ovf_set ? 1'b1 : (status_clr ? 1'b0 : ovf);
      mis <= mis_set ? 1'b1 : (status_clr ? 1'b0 : mis);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cyc_clr)
      cycles <= '0;
    else
      cycles <= cycles + 32'd1;
  end

  assign status = {24'b0, 4'(count), 1'b0, ovf, mis, full};

  // Loads are combinational and see pre-store contents.
  always_comb begin
    rd_data = '0;
    if (!reset && bus.Dread) begin
      if (is_mmio) begin
        case (mmio_off)
          2'd1:    rd_data = status;
          2'd2:    rd_data = cycles;
          default: rd_data = '0;
        endcase
      end else begin
        rd_data = ram[ram_idx];
      end
    end
  end

  assign bus.Din = rd_data;

endmodule
